// File: rtl/tracker_pkg.sv
// Shared tracker types: instrument codes, note bundle and pattern row layout.
// Imported by the tracker and by pattern_sequencer.
package tracker_pkg;

    typedef enum logic [1:0] {
        INSTR_SIN    = 2'd0,
        INSTR_SQUARE = 2'd1,
        INSTR_SAW    = 2'd2,
        INSTR_RAND   = 2'd3
    } instr_e;

    typedef struct packed {
        instr_e instrument;
    } note_tp;

    typedef struct packed {
        instr_e     instrument;
        logic [3:0] speed;
    } row_tp;

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } seq_state_e;

    localparam row_tp ROW_CLEAR = '{instrument: INSTR_SIN, speed: 4'd0};

endpackage

// File: rtl/pattern_sequencer_ram.sv
// pattern_ram: ROWS x row_tp store, one sync write port, one comb read port.
// Read of the row being written this cycle returns the new data.
module pattern_ram
    import tracker_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  row_tp             wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output row_tp             rd_data
);

    row_tp mem [ROWS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= ROW_CLEAR;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: steps through pattern_ram rows, driving note/speed.
// Define SEQ_LOOP_EN to loop back to row 0 at pattern end (else one-shot).
module pattern_sequencer
    import tracker_pkg::*;
#(
    parameter int ROWS           = 16,
    parameter int ADDR_W         = $clog2(ROWS),
    parameter int TICKS_PER_STEP = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_instr,
    input  logic [3:0]        wr_speed,
    input  logic [ADDR_W-1:0] last_row,
    input  logic              play,
    input  logic              stop,
    output note_tp            note,
    output logic [3:0]        speed,
    output logic [ADDR_W-1:0] row,
    output logic              row_strobe,
    output logic              playing
);

    localparam int CNT_W = $clog2(TICKS_PER_STEP);

    seq_state_e        state;
    seq_state_e        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] last_q;
    note_tp            note_q;
    logic [3:0]        speed_q;
    logic              strobe_q;

    logic              load;
    logic              go_idle;
    logic [ADDR_W-1:0] load_addr;
    logic              step_end;
    row_tp             wr_row;
    row_tp             rd_row;

    assign wr_row   = '{instrument: instr_e'(wr_instr), speed: wr_speed};
    assign step_end = (cnt == CNT_W'(TICKS_PER_STEP - 1));

    pattern_ram #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_row),
        .rd_addr (load_addr),
        .rd_data (rd_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        go_idle    = 1'b0;
        load_addr  = '0;
        unique case (state)
            S_IDLE: begin
                if (play && !stop) begin
                    next_state = S_PLAY;
                    load       = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    next_state = S_IDLE;
                    go_idle    = 1'b1;
                end else if (step_end) begin
                    if (row_q == last_q) begin
`ifdef SEQ_LOOP_EN
                        load = 1'b1;
`else
                        next_state = S_IDLE;
                        go_idle    = 1'b1;
`endif
                    end else begin
                        load      = 1'b1;
                        load_addr = row_q + 1'b1;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Row/tick datapath; rows are latched so later RAM writes don't leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            row_q    <= '0;
            last_q   <= '0;
            note_q   <= '{instrument: INSTR_SIN};
            speed_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= load;
            if (state == S_IDLE && load) begin
                last_q <= last_row;
            end
            if (load) begin
                cnt               <= '0;
                row_q             <= load_addr;
                note_q.instrument <= rd_row.instrument;
                speed_q           <= rd_row.speed;
            end else if (go_idle) begin
                cnt      <= '0;
                row_q    <= '0;
                note_q   <= '{instrument: INSTR_SIN};
                speed_q  <= '0;
            end else if (state == S_PLAY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        note       = note_q;
        speed      = speed_q;
        row        = row_q;
        row_strobe = strobe_q;
        playing    = (state == S_PLAY);
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Testbench for pattern_sequencer: directed scenarios plus random traffic,
// every cycle compared against a row/tick reference model.
module tb_pattern_sequencer;
    import tracker_pkg::*;

    localparam int ROWS = 16;
    localparam int AW   = 4;
    localparam int T    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_instr;
    logic [3:0]    wr_speed;
    logic [AW-1:0] last_row;
    logic          play;
    logic          stop;
    note_tp        note;
    logic [3:0]    speed;
    logic [AW-1:0] row;
    logic          row_strobe;
    logic          playing;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [1:0] m_ins [ROWS];
    logic [3:0] m_spd [ROWS];
    bit         m_play;
    int         m_row;
    int         m_last;
    int         m_age;
    logic [1:0] m_oins;
    logic [3:0] m_ospd;
    bit         m_strobe;

    always #5 clk = ~clk;

    pattern_sequencer #(
        .ROWS           (ROWS),
        .TICKS_PER_STEP (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_instr   (wr_instr),
        .wr_speed   (wr_speed),
        .last_row   (last_row),
        .play       (play),
        .stop       (stop),
        .note       (note),
        .speed      (speed),
        .row        (row),
        .row_strobe (row_strobe),
        .playing    (playing)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_idle();
        m_play = 0;
        m_row  = 0;
        m_age  = 0;
        m_oins = 2'd0;
        m_ospd = 4'd0;
    endfunction

    function automatic void m_present(input int r);
        m_play   = 1;
        m_row    = r % ROWS;
        m_age    = 0;
        m_oins   = m_ins[m_row];
        m_ospd   = m_spd[m_row];
        m_strobe = 1;
    endfunction

    function automatic void model_step();
        m_strobe = 0;
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                m_ins[i] = 2'd0;
                m_spd[i] = 4'd0;
            end
            m_last = 0;
            m_idle();
            return;
        end
        if (wr_en) begin
            m_ins[wr_addr] = wr_instr;
            m_spd[wr_addr] = wr_speed;
        end
        if (!m_play) begin
            if (play && !stop) begin
                m_last = int'(last_row);
                m_present(0);
            end
        end else if (stop) begin
            m_idle();
        end else if (m_age == T - 1) begin
            if (m_row == m_last) begin
`ifdef SEQ_LOOP_EN
                m_present(0);
`else
                m_idle();
`endif
            end else begin
                m_present(m_row + 1);
            end
        end else begin
            m_age++;
        end
    endfunction

    // One clock: update model at the edge, compare 1 time unit later, drop pulses.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("instrument", int'(note.instrument), int'(m_oins));
        check("speed", int'(speed), int'(m_ospd));
        check("row", int'(row), m_row);
        check("row_strobe", int'(row_strobe), int'(m_strobe));
        check("playing", int'(playing), int'(m_play));
        rst   = 1'b0;
        wr_en = 1'b0;
        play  = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input int ins, input int spd);
        wr_en    = 1'b1;
        wr_addr  = AW'(a);
        wr_instr = 2'(ins);
        wr_speed = 4'(spd);
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_addr = 0; wr_instr = 0; wr_speed = 0;
        last_row = 0; play = 0; stop = 0;
        for (int i = 0; i < ROWS; i++) begin
            m_ins[i] = 0;
            m_spd[i] = 0;
        end
        m_last = 0; m_strobe = 0;
        m_idle();
        tick();
        check("reset_playing", int'(playing), 0);
        check("reset_speed", int'(speed), 0);

        for (int i = 0; i < 4; i++) begin
            wr(i, i, i + 1);
            tick();
        end
        last_row = 3;
        play = 1'b1;
        tick();
        check("play_ins", int'(note.instrument), int'(INSTR_SIN));
        check("play_speed", int'(speed), 1);
        check("play_strobe", int'(row_strobe), 1);
        ticks(4);
        check("row1_ins", int'(note.instrument), int'(INSTR_SQUARE));
        check("row1_speed", int'(speed), 2);
        ticks(12);
        ticks(6);
        stop = 1'b1; tick();

        // stop two cycles into row 1, then replay from row 0
        play = 1'b1; tick();
        ticks(6);
        stop = 1'b1; tick();
        check("stop_playing", int'(playing), 0);
        check("stop_row", int'(row), 0);
        play = 1'b1; tick();
        check("replay_speed", int'(speed), 1);
        stop = 1'b1; tick();

        // play+stop together in idle
        play = 1'b1; stop = 1'b1; tick();
        check("ps_idle", int'(playing), 0);

        // play again during row 2
        play = 1'b1; tick();
        ticks(9);
        play = 1'b1; tick();
        ticks(10);
        stop = 1'b1; tick();

        // overwrite row 2 while it is playing
        play = 1'b1; tick();
        ticks(9);
        wr(2, 1, 9); tick();
        check("ovr_hold", int'(speed), 3);
        ticks(24);
        stop = 1'b1; tick();

        // reset mid-row 1
        play = 1'b1; tick();
        ticks(5);
        rst = 1'b1; tick();
        check("rst_mid", int'(playing), 0);
        play = 1'b1; tick();
        check("post_rst_speed", int'(speed), 0);
        check("post_rst_play", int'(playing), 1);

        // last_row = ROWS-1 wraps modulo ROWS
        stop = 1'b1; tick();
        last_row = AW'(ROWS - 1);
        play = 1'b1; tick();
        ticks(T * ROWS + 8);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 30)
                wr($urandom_range(0, ROWS - 1), $urandom_range(0, 3), $urandom_range(0, 15));
            last_row = AW'($urandom_range(0, ROWS - 1));
            play = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
